ekf_stage_seq: RTL and testbench
================================

EKF_STAGE_SEQ -- requirements
Module: ekf_stage_seq

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- FIFO_DEPTH, 4, command FIFO entries (power of two)
- TO_CYCLES, 65535, watchdog limit in cycles while a stage is outstanding
REQ-002 The block SHALL have these ports, one per line (name direction width meaning):
- clk  in  1  single clock; all logic is rising-edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command FIFO can accept
- cmd_type  in  2  0=predict, 1=newlm, 2=update, 3=reserved
- cmd_d0  in  32  signed; vlr (predict) or rk (newlm/update)
- cmd_d1  in  32  signed; alpha (predict) or phi (newlm/update)
- stage_val  out  3  one-hot stage request: bit0 predict, bit1 newlm, bit2 update
- stage_rdy  in  3  one-cycle stage-complete pulses from the EKF core, same bit map
- vlr, alpha, rk, phi  out  32 each  signed operands held for the core
- busy  out  1  a stage is outstanding or the FIFO is non-empty
- stage_cnt  out  16  completed-stage count, wraps 0xFFFF->0
- err_type  out  1  sticky: reserved command type was offered
- err_timeout  out  1  sticky: watchdog aborted a stage
- err_clr  in  1  clears both sticky flags

Function
REQ-003 A command SHALL be accepted on an edge where cmd_val=1 and cmd_rdy=1; cmd_rdy SHALL equal (FIFO count < FIFO_DEPTH), computed from the registered count, so a push is refused at full even when a pop occurs in the same cycle.
REQ-004 An accepted cmd_type=3 SHALL NOT be stored; it SHALL set err_type.
REQ-005 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop at non-full/non-empty SHALL leave the count unchanged.
REQ-006 The FSM SHALL have states IDLE, ISSUE, GAP.
REQ-007 IDLE: when the FIFO is non-empty, pop the head and go to ISSUE on that edge, driving stage_val to the one-hot of the popped type.
REQ-008 On the pop edge, predict SHALL load vlr<=d0 and alpha<=d1; newlm/update SHALL load rk<=d0 and phi<=d1; non-loaded operand registers SHALL hold their previous values.
REQ-009 Operand outputs and stage_val SHALL stay constant throughout ISSUE.
REQ-010 ISSUE: when (stage_rdy & stage_val)!=0, go to GAP, clear stage_val, increment stage_cnt; non-matching stage_rdy bits SHALL be ignored.
REQ-011 ISSUE: a watchdog counter SHALL start at 0 on entry, increment every ISSUE cycle, and when it reaches TO_CYCLES without completion, set err_timeout, clear stage_val, go to GAP without incrementing stage_cnt.
REQ-012 Completion in the same cycle the watchdog reaches TO_CYCLES SHALL count as completion (no error).
REQ-013 GAP SHALL last exactly one cycle with stage_val=0, then go to IDLE; back-to-back stages are therefore separated by at least one stage_val=0 cycle.
REQ-014 Minimum latency: command accepted at edge N into an empty FIFO while in IDLE -> stage_val asserted after edge N+1.
REQ-015 busy SHALL be 1 when state!=IDLE or FIFO count!=0.
REQ-016 err_clr=1 SHALL clear the sticky flags; a set event in the same cycle SHALL win.
REQ-017 stage_val SHALL never have more than one bit set.

Reset
REQ-018 sys_rst_n=0 SHALL immediately and asynchronously force state IDLE, FIFO empty, stage_val=0, all operands=0, stage_cnt=0, err_type=0, err_timeout=0, busy=0, watchdog=0; cmd_rdy SHALL be 1 after reset.
REQ-019 Reset during ISSUE SHALL drop the outstanding stage and discard all queued commands; no completion is counted.

Verification
REQ-020 Predict cmd (d0=0x00010000, d1=0x00008000) -> stage_val=001 one cycle after accept, vlr/alpha match; stage_rdy=001 pulse -> stage_val=0, stage_cnt=1.
REQ-021 Push 5 commands while core stalls, FIFO_DEPTH=4 -> first pops immediately, next 4 fill FIFO, cmd_rdy=0 on the 6th offer; issue order = push order.
REQ-022 In ISSUE on update, pulse stage_rdy=001 -> ignored, stage_val stays 100; then 100 -> completes.
REQ-023 TO_CYCLES=8, no stage_rdy -> stage_val drops after 8 ISSUE cycles, err_timeout=1, stage_cnt unchanged; err_clr -> 0.
REQ-024 cmd_type=3 -> err_type=1, FIFO count unchanged, stage_val stays 000.
REQ-025 sys_rst_n low mid-ISSUE with 2 queued -> all outputs at reset values without a clock edge; busy=0 after release.

Source files
------------

// File: rtl/ekf_stage_seq_if.sv
// rtl/ekf_stage_seq_if.sv - command and stage handshake bundle for the EKF stage sequencer
interface ekf_stage_seq_if;
  logic               cmd_val;
  logic               cmd_rdy;
  logic [1:0]         cmd_type;
  logic signed [31:0] cmd_d0;
  logic signed [31:0] cmd_d1;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  logic signed [31:0] vlr;
  logic signed [31:0] alpha;
  logic signed [31:0] rk;
  logic signed [31:0] phi;

  modport master (
    input  cmd_val, cmd_type, cmd_d0, cmd_d1, stage_rdy,
    output cmd_rdy, stage_val, vlr, alpha, rk, phi
  );

  modport slave (
    output cmd_val, cmd_type, cmd_d0, cmd_d1, stage_rdy,
    input  cmd_rdy, stage_val, vlr, alpha, rk, phi
  );
endinterface

// File: rtl/ekf_stage_seq.sv
// rtl/ekf_stage_seq.sv - EKF stage sequencer: command FIFO feeding a one-hot stage issue FSM
// with a per-stage watchdog, completion counter and sticky error flags.
module ekf_stage_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYCLES  = 65535
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  ekf_stage_seq_if.master bus,
  output logic            busy,
  output logic [15:0]     stage_cnt,
  output logic            err_type,
  output logic            err_timeout,
  input  logic            err_clr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t             r_state;
  logic [1:0]         r_mem_type [FIFO_DEPTH];
  logic signed [31:0] r_mem_d0   [FIFO_DEPTH];
  logic signed [31:0] r_mem_d1   [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [WW-1:0]      r_wd;
  logic [2:0]         r_stage_val;
  logic signed [31:0] r_vlr;
  logic signed [31:0] r_alpha;
  logic signed [31:0] r_rk;
  logic signed [31:0] r_phi;
  logic [15:0]        r_stage_cnt;
  logic               r_err_type;
  logic               r_err_timeout;

  logic               w_cmd_rdy;
  logic               w_accept;
  logic               w_push;
  logic               w_bad;
  logic               w_pop;
  logic [1:0]         w_head_type;
  logic [2:0]         w_head_onehot;
  logic               w_done;
  logic               w_expire;

  // Readiness comes from the registered count only, so a pop cannot open a slot in the same cycle.
  assign w_cmd_rdy   = (r_count < CW'(FIFO_DEPTH));
  assign w_accept    = bus.cmd_val & w_cmd_rdy;
  assign w_bad       = w_accept & (bus.cmd_type == 2'd3);
  assign w_push      = w_accept & (bus.cmd_type != 2'd3);
  assign w_pop       = (r_state == S_IDLE) & (r_count != '0);
  assign w_head_type = r_mem_type[r_rd_ptr];
  assign w_done      = (bus.stage_rdy & r_stage_val) != 3'b000;
  assign w_expire    = (r_wd == WW'(TO_CYCLES - 1));

  always_comb begin
    w_head_onehot = 3'b100;
    case (w_head_type)
      2'd0:    w_head_onehot = 3'b001;
      2'd1:    w_head_onehot = 3'b010;
      default: w_head_onehot = 3'b100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_type[r_wr_ptr] <= bus.cmd_type;
      r_mem_d0[r_wr_ptr]   <= bus.cmd_d0;
      r_mem_d1[r_wr_ptr]   <= bus.cmd_d1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clears are written before the sets so a same-cycle set event takes precedence.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_stage_val   <= 3'b000;
      r_wd          <= '0;
      r_vlr         <= '0;
      r_alpha       <= '0;
      r_rk          <= '0;
      r_phi         <= '0;
      r_stage_cnt   <= '0;
      r_err_type    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (err_clr) begin
        r_err_type    <= 1'b0;
        r_err_timeout <= 1'b0;
      end
      if (w_bad) r_err_type <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state     <= S_ISSUE;
            r_stage_val <= w_head_onehot;
            r_wd        <= '0;
            if (w_head_type == 2'd0) begin
              r_vlr   <= r_mem_d0[r_rd_ptr];
              r_alpha <= r_mem_d1[r_rd_ptr];
            end else begin
              r_rk    <= r_mem_d0[r_rd_ptr];
              r_phi   <= r_mem_d1[r_rd_ptr];
            end
          end
        end
        S_ISSUE: begin
          if (w_done) begin
            r_state     <= S_GAP;
            r_stage_val <= 3'b000;
            r_stage_cnt <= r_stage_cnt + 16'd1;
          end else if (w_expire) begin
            r_state       <= S_GAP;
            r_stage_val   <= 3'b000;
            r_err_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
          r_wd    <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_stage_val <= 3'b000;
        end
      endcase
    end
  end

  assign bus.cmd_rdy   = w_cmd_rdy;
  assign bus.stage_val = r_stage_val;
  assign bus.vlr       = r_vlr;
  assign bus.alpha     = r_alpha;
  assign bus.rk        = r_rk;
  assign bus.phi       = r_phi;
  assign busy          = (r_state != S_IDLE) | (r_count != '0);
  assign stage_cnt     = r_stage_cnt;
  assign err_type      = r_err_type;
  assign err_timeout   = r_err_timeout;
endmodule

// File: tb/tb_ekf_stage_seq.sv
// tb/tb_ekf_stage_seq.sv - directed self-checking bench for ekf_stage_seq
module tb_ekf_stage_seq;
  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        busy;
  logic [15:0] stage_cnt;
  logic        err_type;
  logic        err_timeout;
  logic        err_clr;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;

  ekf_stage_seq_if bus();

  ekf_stage_seq #(.FIFO_DEPTH(4), .TO_CYCLES(8)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus), .busy(busy),
    .stage_cnt(stage_cnt), .err_type(err_type), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.stage_val != 3'b000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic offer(input logic [1:0] t, input logic [31:0] d0, input logic [31:0] d1);
    bus.cmd_val = 1'b1; bus.cmd_type = t; bus.cmd_d0 = d0; bus.cmd_d1 = d1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; err_clr = 1'b0;
    bus.cmd_val = 1'b0; bus.cmd_type = 2'd0; bus.cmd_d0 = '0; bus.cmd_d1 = '0; bus.stage_rdy = 3'b000;
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    n_checks++; if (bus.stage_val !== 3'b000) begin n_errors++; $display("FAIL reset_stage_val: got %b exp 000", bus.stage_val); end
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_rdy: got %b exp 1", bus.cmd_rdy); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (stage_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_stage_cnt: got %0d exp 0", stage_cnt); end
    n_checks++; if ({err_type, err_timeout} !== 2'b00) begin n_errors++; $display("FAIL reset_errs: got %b exp 00", {err_type, err_timeout}); end
    n_checks++; if ({bus.vlr, bus.alpha, bus.rk, bus.phi} !== 128'd0) begin n_errors++; $display("FAIL reset_operands: got %h exp 0", {bus.vlr, bus.alpha, bus.rk, bus.phi}); end
  endtask

  task automatic test_predict();
    offer(2'd0, 32'h0001_0000, 32'h0000_8000);
    tick();
    bus.cmd_val = 1'b0;
    n_checks++; if (bus.stage_val !== 3'b000) begin n_errors++; $display("FAIL predict_latency_early: got %b exp 000", bus.stage_val); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL predict_busy_queued: got %b exp 1", busy); end
    tick();
    n_checks++; if (bus.stage_val !== 3'b001) begin n_errors++; $display("FAIL predict_stage_val: got %b exp 001", bus.stage_val); end
    n_checks++; if (bus.vlr !== 32'h0001_0000) begin n_errors++; $display("FAIL predict_vlr: got %h exp 00010000", bus.vlr); end
    n_checks++; if (bus.alpha !== 32'h0000_8000) begin n_errors++; $display("FAIL predict_alpha: got %h exp 00008000", bus.alpha); end
    tick(); tick();
    n_checks++; if ({bus.stage_val, bus.vlr, bus.alpha} !== {3'b001, 32'h0001_0000, 32'h0000_8000}) begin n_errors++; $display("FAIL predict_hold: got %b %h %h", bus.stage_val, bus.vlr, bus.alpha); end
    bus.stage_rdy = 3'b001;
    tick();
    bus.stage_rdy = 3'b000;
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (bus.stage_val !== 3'b000) begin n_errors++; $display("FAIL predict_done_sv: got %b exp 000", bus.stage_val); end
    n_checks++; if (stage_cnt !== exp_cnt) begin n_errors++; $display("FAIL predict_cnt: got %0d exp %0d", stage_cnt, exp_cnt); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL predict_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_fifo_full();
    logic [1:0]  types [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] d0s   [5] = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
    logic [31:0] d1s   [5] = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
    logic [2:0]  oh    [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      offer(types[i], d0s[i], d1s[i]);
      n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL fill_rdy_%0d: got %b exp 1", i, bus.cmd_rdy); end
      tick();
    end
    offer(2'd2, 32'h77, 32'h78);
    n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL full_rdy: got %b exp 0", bus.cmd_rdy); end
    tick();
    bus.cmd_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_stage(ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL order_wait_%0d: got no stage exp %b", i, oh[i]); end
      n_checks++; if (bus.stage_val !== oh[i]) begin n_errors++; $display("FAIL order_sv_%0d: got %b exp %b", i, bus.stage_val, oh[i]); end
      if (types[i] == 2'd0) begin
        n_checks++; if ({bus.vlr, bus.alpha} !== {d0s[i], d1s[i]}) begin n_errors++; $display("FAIL order_ops_%0d: got %h %h exp %h %h", i, bus.vlr, bus.alpha, d0s[i], d1s[i]); end
      end else begin
        n_checks++; if ({bus.rk, bus.phi} !== {d0s[i], d1s[i]}) begin n_errors++; $display("FAIL order_ops_%0d: got %h %h exp %h %h", i, bus.rk, bus.phi, d0s[i], d1s[i]); end
      end
      bus.stage_rdy = oh[i];
      tick();
      bus.stage_rdy = 3'b000;
      exp_cnt = exp_cnt + 16'd1;
    end
    tick(); tick(); tick(); tick();
    n_checks++; if ({bus.stage_val, busy} !== 4'b0000) begin n_errors++; $display("FAIL refused_not_stored: got sv=%b busy=%b exp 000 0", bus.stage_val, busy); end
    n_checks++; if (stage_cnt !== exp_cnt) begin n_errors++; $display("FAIL fill_cnt: got %0d exp %0d", stage_cnt, exp_cnt); end
  endtask

  task automatic test_mask();
    bit ok;
    offer(2'd2, 32'h111, 32'hFFFF_FFFB);
    tick();
    bus.cmd_val = 1'b0;
    wait_stage(ok);
    n_checks++; if (bus.stage_val !== 3'b100) begin n_errors++; $display("FAIL mask_sv: got %b exp 100", bus.stage_val); end
    n_checks++; if ({bus.rk, bus.phi} !== {32'h111, 32'hFFFF_FFFB}) begin n_errors++; $display("FAIL mask_ops: got %h %h exp 111 fffffffb", bus.rk, bus.phi); end
    n_checks++; if ({bus.vlr, bus.alpha} !== {32'd7, 32'd8}) begin n_errors++; $display("FAIL mask_hold_pred: got %h %h exp 7 8", bus.vlr, bus.alpha); end
    bus.stage_rdy = 3'b001; tick(); bus.stage_rdy = 3'b000;
    n_checks++; if ({bus.stage_val, stage_cnt} !== {3'b100, exp_cnt}) begin n_errors++; $display("FAIL mask_ignore_001: got %b %0d exp 100 %0d", bus.stage_val, stage_cnt, exp_cnt); end
    bus.stage_rdy = 3'b010; tick(); bus.stage_rdy = 3'b000;
    n_checks++; if ({bus.stage_val, stage_cnt} !== {3'b100, exp_cnt}) begin n_errors++; $display("FAIL mask_ignore_010: got %b %0d exp 100 %0d", bus.stage_val, stage_cnt, exp_cnt); end
    bus.stage_rdy = 3'b100; tick(); bus.stage_rdy = 3'b000;
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if ({bus.stage_val, stage_cnt} !== {3'b000, exp_cnt}) begin n_errors++; $display("FAIL mask_complete: got %b %0d exp 000 %0d", bus.stage_val, stage_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    offer(2'd0, 32'h5, 32'h6);
    tick();
    bus.cmd_val = 1'b0;
    wait_stage(ok);
    n = 0;
    while (bus.stage_val != 3'b000 && n < 20) begin
      tick();
      n++;
    end
    n_checks++; if (n !== 8) begin n_errors++; $display("FAIL timeout_cycles: got %0d exp 8", n); end
    n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_flag: got %b exp 1", err_timeout); end
    n_checks++; if (stage_cnt !== exp_cnt) begin n_errors++; $display("FAIL timeout_cnt: got %0d exp %0d", stage_cnt, exp_cnt); end
    tick(); tick();
    n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %b exp 1", err_timeout); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: got %b exp 0", err_timeout); end
  endtask

  task automatic test_wd_boundary();
    bit ok;
    offer(2'd1, 32'h21, 32'h22);
    tick();
    bus.cmd_val = 1'b0;
    wait_stage(ok);
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (bus.stage_val !== 3'b010) begin n_errors++; $display("FAIL wd_last_cycle_sv: got %b exp 010", bus.stage_val); end
    bus.stage_rdy = 3'b010; tick(); bus.stage_rdy = 3'b000;
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if ({bus.stage_val, err_timeout} !== 4'b0000) begin n_errors++; $display("FAIL wd_boundary_done: got sv=%b to=%b exp 000 0", bus.stage_val, err_timeout); end
    n_checks++; if (stage_cnt !== exp_cnt) begin n_errors++; $display("FAIL wd_boundary_cnt: got %0d exp %0d", stage_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_bad_type();
    offer(2'd3, 32'hDEAD, 32'hBEEF);
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL bad_rdy: got %b exp 1", bus.cmd_rdy); end
    tick();
    bus.cmd_val = 1'b0;
    n_checks++; if (err_type !== 1'b1) begin n_errors++; $display("FAIL bad_err_type: got %b exp 1", err_type); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL bad_not_queued: got busy=%b exp 0", busy); end
    tick(); tick();
    n_checks++; if (bus.stage_val !== 3'b000) begin n_errors++; $display("FAIL bad_no_stage: got %b exp 000", bus.stage_val); end
    offer(2'd3, 32'h1, 32'h2); err_clr = 1'b1;
    tick();
    bus.cmd_val = 1'b0; err_clr = 1'b0;
    n_checks++; if (err_type !== 1'b1) begin n_errors++; $display("FAIL bad_set_wins: got %b exp 1", err_type); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err_type !== 1'b0) begin n_errors++; $display("FAIL bad_clear: got %b exp 0", err_type); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    offer(2'd0, 32'h31, 32'h32); tick();
    offer(2'd1, 32'h33, 32'h34); tick();
    offer(2'd2, 32'h35, 32'h36); tick();
    bus.cmd_val = 1'b0;
    wait_stage(ok);
    n_checks++; if (!ok || busy !== 1'b1) begin n_errors++; $display("FAIL rst_mid_setup: got ok=%b busy=%b exp 1 1", ok, busy); end
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.stage_val, busy, bus.cmd_rdy} !== 5'b00001) begin n_errors++; $display("FAIL rst_mid_async: got sv=%b busy=%b rdy=%b exp 000 0 1", bus.stage_val, busy, bus.cmd_rdy); end
    n_checks++; if ({bus.vlr, bus.alpha, bus.rk, bus.phi} !== 128'd0) begin n_errors++; $display("FAIL rst_mid_ops: got %h exp 0", {bus.vlr, bus.alpha, bus.rk, bus.phi}); end
    n_checks++; if ({stage_cnt, err_type, err_timeout} !== 18'd0) begin n_errors++; $display("FAIL rst_mid_cnt_errs: got %0d %b %b exp 0 0 0", stage_cnt, err_type, err_timeout); end
    #2;
    sys_rst_n = 1'b1;
    tick(); tick(); tick();
    n_checks++; if ({bus.stage_val, busy} !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_release: got sv=%b busy=%b exp 000 0", bus.stage_val, busy); end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_fifo_full();
    test_mask();
    test_timeout();
    test_wd_boundary();
    test_bad_type();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t exp finished", $time);
    $fatal(1);
  end
endmodule
